// File: rtl/radix4_pkg.sv
// radix4_pkg: shared FSM encoding, Booth digit type and recode table for radix4_mul_ctrl.
package radix4_pkg;
  localparam int DIGITS = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} mul_state_e;
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;
  function automatic booth_digit_t recode(input logic [2:0] t);
    recode.neg  = t[2] & ~(t[1] & t[0]);
    recode.two  = (t == 3'b011) | (t == 3'b100);
    recode.zero = (t == 3'b000) | (t == 3'b111);
  endfunction
endpackage

// File: rtl/booth_recode.sv
// booth_recode: maps a radix-4 Booth triplet {b[2k+1], b[2k], b[2k-1]} to {neg, two, zero}.
module booth_recode
  import radix4_pkg::*;
(
  input  logic [2:0] trip_i,
  output logic       neg_o,
  output logic       two_o,
  output logic       zero_o
);
  booth_digit_t d;
  assign d = recode(trip_i);
  assign neg_o = d.neg;
  assign two_o = d.two;
  assign zero_o = d.zero;
endmodule

// File: rtl/radix4_mul_ctrl.sv
// radix4_mul_ctrl: sequential radix-4 Booth multiplier, one digit per clock; RADIX4_EARLY_TERM_EN stops once the remaining digits are all zero.
module radix4_mul_ctrl
  import radix4_pkg::*;
#(
  parameter int W = 2 * DIGITS
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_valid_i,
  output logic           start_ready_o,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic [2*W-1:0] res_o,
  output logic           busy_o
);
  localparam int D = W / 2;
  localparam int KW = (D > 1) ? $clog2(D) : 1;
  mul_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d, res_q, res_d, sum, pp_ext;
  logic [W+1:0] a_x, mag, pp;
  logic [2:0] trip;
  logic neg, two, zero, last;
  assign trip = 3'({b_q, 1'b0} >> {k_q, 1'b0});
  booth_recode u_rec (.trip_i(trip), .neg_o(neg), .two_o(two), .zero_o(zero));
  // W+2 bits hold every d*A, including -2 * -2^(W-1)
  assign a_x = {{2{a_q[W-1]}}, a_q};
  assign mag = two ? {a_x[W:0], 1'b0} : a_x;
  assign pp = zero ? '0 : neg ? -mag : mag;
  assign pp_ext = {{(W-2){pp[W+1]}}, pp};
  assign sum = acc_q + (pp_ext << {k_q, 1'b0});
`ifdef RADIX4_EARLY_TERM_EN
  logic signed [W-1:0] b_hi;
  assign b_hi = $signed(b_q) >>> {k_q, 1'b1};
  assign last = (k_q == KW'(D - 1)) | (b_hi == '0) | (b_hi == '1);
`else
  assign last = k_q == KW'(D - 1);
`endif
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    res_d = res_q;
    if (state_q == IDLE && start_valid_i) begin
      state_d = CALC;
      a_d = a_i;
      b_d = b_i;
      acc_d = '0;
      k_d = '0;
    end else if (state_q == CALC) begin
      acc_d = sum;
      k_d = k_q + 1'b1;
      state_d = last ? DONE : CALC;
      res_d = last ? sum : res_q;
    end else if (state_q == DONE && res_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
  assign start_ready_o = state_q == IDLE;
  assign res_valid_o = state_q == DONE;
  assign busy_o = state_q != IDLE;
  assign res_o = res_q;
endmodule

// File: tb/tb_radix4_mul_ctrl.sv
// tb_radix4_mul_ctrl: scoreboard bench for radix4_mul_ctrl (W=8), honours RADIX4_EARLY_TERM_EN for latency expectations.
module tb_radix4_mul_ctrl;
  logic clk = 0, rst_ni = 0, start_valid_i = 0, res_ready_i = 0;
  logic start_ready_o, res_valid_o, busy_o;
  logic [7:0] a_i = 0, b_i = 0;
  logic [15:0] res_o;
  int checks = 0, passed = 0, ready_mode = 0;
  logic [15:0] q[$];

  radix4_mul_ctrl #(.W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .a_i(a_i), .b_i(b_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[15:0];
  endfunction

  // cycles needed: fewest digits n whose 2n-bit signed range holds B
  function automatic int lat(input logic [7:0] b);
`ifdef RADIX4_EARLY_TERM_EN
    for (int n = 1; n < 4; n++)
      if (int'($signed(b)) >= -(1 << (2*n-1)) && int'($signed(b)) < (1 << (2*n-1))) return n;
`endif
    return 4;
  endfunction

  initial forever begin
    @(posedge clk); #2;
    res_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (rst_ni && res_valid_o && res_ready_i) begin
      if (q.size() > 0) chk("result", res_o, q.pop_front());
      else chk("unexpected_result", q.size(), 1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n;
    bit ok, sr_low;
    start_valid_i = 1; a_i = a; b_i = b; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = start_ready_o; end
    if (!ok) begin chk("accept_timeout", ok, 1); start_valid_i = 0; return; end
    q.push_back(exp);
    @(posedge clk); #1;
    start_valid_i = 0; a_i = 8'($urandom); b_i = 8'($urandom);
    n = 0; sr_low = 1; ok = 0;
    while (!ok && n < 20) begin
      @(posedge clk); n++; #1;
      ok = res_valid_o;
      if (start_ready_o) sr_low = 0;
    end
    chk("latency", n, lat(b));
    chk("start_ready_low", sr_low, 1);
  endtask

  task automatic drain();
    ready_mode = 0;
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", res_o, 0);
    chk("rst_valid", res_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", start_ready_o, 1);
    rst_ni = 1;
    @(posedge clk); #1;
    issue(8'd3, 8'd5, 16'd15);
    @(posedge clk); #1;
    chk("ready_after_hs", start_ready_o, 1);
    issue(8'h80, 8'h80, 16'h4000);
    issue(8'h80, 8'h7F, 16'hC080);
    issue(8'd9, 8'd0, 16'h0000);
    issue(8'd9, 8'hFF, 16'hFFF7);
    issue(8'd9, 8'h40, 16'h0240);
    drain();
    ready_mode = 2;
    issue(8'd77, 8'hB3, prod(8'd77, 8'hB3));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start_valid_i = 1; a_i = 8'd1; b_i = 8'd1; end
      if (i == 4) start_valid_i = 0;
      @(posedge clk); #1;
      chk("stall_valid", res_valid_o, 1);
      chk("stall_res", res_o, prod(8'd77, 8'hB3));
    end
    drain();
    @(posedge clk); #1;
    start_valid_i = 1; a_i = 8'd100; b_i = 8'hB3;
    @(negedge clk);
    @(posedge clk); #1;
    start_valid_i = 0;
    @(posedge clk); #1;
    rst_ni = 0;
    @(posedge clk); #1;
    chk("abort_res", res_o, 0);
    chk("abort_valid", res_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", start_ready_o, 1);
    rst_ni = 1;
    issue(8'd7, 8'hFA, 16'hFFD6);
    drain();
    ready_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hFF;
      issue(ra, rb, prod(ra, rb));
    end
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
